systolic_skew_feeder: RTL and testbench

- Upstream operand stage for the 4x4 Booth systolic array.
- Collects 32 operand bytes from the UART receive path: 16 bytes of matrix A, then 16 bytes of matrix B, each row-major.
- Stores them in internal register files, resets the array for one cycle, then drives the diagonally skewed row and column streams onto the array's A0..A3 / B0..B3 inputs.
- Waits for the array's done pulse, then re-arms for the next operand set.

---
 rtl/systolic_pkg.sv | 18 +
 rtl/skew_select.sv | 22 ++
 rtl/systolic_skew_feeder.sv | 186 ++++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants for the systolic operand feeder: widths, feed length,
// FSM encodings and operand slot base offsets.
package systolic_pkg;

    localparam int unsigned DW       = 8;
    localparam int unsigned N        = 4;
    localparam int unsigned FEED_LEN = 2 * N - 1;

    localparam int unsigned A_BASE = 0;
    localparam int unsigned B_BASE = 16;

    localparam logic [2:0] LOAD  = 3'd0;
    localparam logic [2:0] READY = 3'd1;
    localparam logic [2:0] ARM   = 3'd2;
    localparam logic [2:0] FEED  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

endpackage

// File: rtl/skew_select.sv
// Picks element (t - lane) of a 4-entry operand vector, or zero when the
// diagonal wavefront has not reached or has already passed this lane.
module skew_select #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4
) (
    input  logic [2:0]              t_i,
    input  logic [2:0]              lane_i,
    input  logic [N-1:0][DW-1:0]    vec_i,
    output logic [DW-1:0]           sel_o
);

    always_comb begin
        sel_o = '0;
        for (int k = 0; k < N; k++) begin
            if (t_i == lane_i + 3'(k)) begin
                sel_o = vec_i[k];
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Collects A and B operand bytes from the UART path and streams them with a
// diagonal skew into the 4x4 systolic array, then waits for its done flag.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned DW            = 8,
    parameter int unsigned N             = 4,
    parameter int unsigned DRAIN_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    input  logic          start,
    input  logic          arr_done,
    output logic          rx_ready,
    output logic [DW-1:0] A0,
    output logic [DW-1:0] A1,
    output logic [DW-1:0] A2,
    output logic [DW-1:0] A3,
    output logic [DW-1:0] B0,
    output logic [DW-1:0] B1,
    output logic [DW-1:0] B2,
    output logic [DW-1:0] B3,
    output logic          arr_rst,
    output logic          busy,
    output logic          drop_err,
    output logic          timeout_err,
    output logic [2:0]    state_o
);

    localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);

    logic [2:0]    state_q, state_d;
    logic [4:0]    byte_cnt_q, byte_cnt_d;
    logic [2:0]    t_q, t_d;
    logic [TW-1:0] drain_cnt_q, drain_cnt_d;
    logic          drop_err_q, timeout_err_q, timeout_err_d;
    logic          timeout_hit;
    logic          accept;

    logic [DW-1:0] mem_q [2*N*N];
    logic [DW-1:0] a_sel [N];
    logic [DW-1:0] b_sel [N];
    logic [DW-1:0] a_q   [N];
    logic [DW-1:0] a_d   [N];
    logic [DW-1:0] b_q   [N];
    logic [DW-1:0] b_d   [N];

    assign rx_ready = (state_q == LOAD);
    assign accept   = rx_valid & rx_ready;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        t_d         = t_q;
        drain_cnt_d = drain_cnt_q;
        timeout_hit = 1'b0;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (byte_cnt_q == 5'd31) begin
                        byte_cnt_d = 5'd0;
                        state_d    = READY;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end
            end
            READY: begin
                if (start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                t_d     = 3'd0;
                state_d = FEED;
            end
            FEED: begin
                if (t_q == 3'(FEED_LEN - 1)) begin
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            DRAIN: begin
                if (arr_done) begin
                    state_d = LOAD;
                end else if (drain_cnt_q == TW'(DRAIN_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = LOAD;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        timeout_err_d = timeout_err_q;
        if (timeout_hit) begin
            timeout_err_d = 1'b1;
        end else if (accept) begin
            timeout_err_d = 1'b0;
        end
    end

    // Lane selectors look at the next t so the output registers hold the
    // value belonging to the cycle the FSM is about to enter.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [N-1:0][DW-1:0] a_vec;
        logic [N-1:0][DW-1:0] b_vec;
        for (genvar k = 0; k < N; k++) begin : g_elem
            assign a_vec[k] = mem_q[A_BASE + N * i + k];
            assign b_vec[k] = mem_q[B_BASE + N * k + i];
        end

        skew_select #(.DW(DW), .N(N)) u_sel_a (
            .t_i    (t_d),
            .lane_i (3'(i)),
            .vec_i  (a_vec),
            .sel_o  (a_sel[i])
        );

        skew_select #(.DW(DW), .N(N)) u_sel_b (
            .t_i    (t_d),
            .lane_i (3'(i)),
            .vec_i  (b_vec),
            .sel_o  (b_sel[i])
        );

        assign a_d[i] = (state_d == FEED) ? a_sel[i] : '0;
        assign b_d[i] = (state_d == FEED) ? b_sel[i] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= LOAD;
            byte_cnt_q    <= 5'd0;
            t_q           <= 3'd0;
            drain_cnt_q   <= '0;
            drop_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            t_q           <= t_d;
            drain_cnt_q   <= drain_cnt_d;
            drop_err_q    <= rx_valid & ~rx_ready;
            timeout_err_q <= timeout_err_d;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            mem_q[byte_cnt_q] <= rx_data;
        end
    end

    // Streams are forced low during reset so the array sees zeros at once.
    assign A0 = reset ? '0 : a_q[0];
    assign A1 = reset ? '0 : a_q[1];
    assign A2 = reset ? '0 : a_q[2];
    assign A3 = reset ? '0 : a_q[3];
    assign B0 = reset ? '0 : b_q[0];
    assign B1 = reset ? '0 : b_q[1];
    assign B2 = reset ? '0 : b_q[2];
    assign B3 = reset ? '0 : b_q[3];

    assign arr_rst     = reset | (state_q == ARM);
    assign busy        = (state_q == ARM) | (state_q == FEED) | (state_q == DRAIN);
    assign drop_err    = drop_err_q;
    assign timeout_err = timeout_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: loads operand frames over the
// byte interface and scoreboards the skewed A/B streams against a model.
module tb_systolic_skew_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       start;
    logic       arr_done;
    logic       rx_ready;
    logic [7:0] A0, A1, A2, A3, B0, B1, B2, B3;
    logic       arr_rst;
    logic       busy;
    logic       drop_err;
    logic       timeout_err;
    logic [2:0] state_o;

    systolic_skew_feeder #(.DW(8), .N(4), .DRAIN_TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .start       (start),
        .arr_done    (arr_done),
        .rx_ready    (rx_ready),
        .A0          (A0),
        .A1          (A1),
        .A2          (A2),
        .A3          (A3),
        .B0          (B0),
        .B1          (B1),
        .B2          (B2),
        .B3          (B3),
        .arr_rst     (arr_rst),
        .busy        (busy),
        .drop_err    (drop_err),
        .timeout_err (timeout_err),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] frame [32];
    vec_t       tbl [3];
    vec_t       sb [$];

    function automatic logic [7:0] model_a(int i, int t);
        int c = t - i;
        if (c >= 0 && c <= 3) return frame[i * 4 + c];
        return 8'h00;
    endfunction

    function automatic logic [7:0] model_b(int j, int t);
        int r = t - j;
        if (r >= 0 && r <= 3) return frame[16 + r * 4 + j];
        return 8'h00;
    endfunction

    function automatic vec_t model_vec(int t);
        vec_t v;
        v.t = t;
        for (int i = 0; i < 4; i++) begin
            v.a[i*8 +: 8] = model_a(i, t);
            v.b[i*8 +: 8] = model_b(i, t);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(frame[i]);
    endtask

    task automatic random_frame();
        for (int i = 0; i < 32; i++) frame[i] = 8'($urandom_range(1, 255));
    endtask

    task automatic run_feed(input int abort_t, input bit use_tbl);
        int first;
        first = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("arm_state", 32'(state_o), 32'd2);
        chk("arm_rst", 32'(arr_rst), 32'd1);
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_a0", 32'(A0), 32'd0);
        sb.delete();
        for (int t = 0; t < 7; t++) sb.push_back(model_vec(t));
        for (int c = 0; c < 12 && sb.size() > 0; c++) begin
            step();
            if (state_o == 3'd3) begin
                vec_t e;
                e = sb.pop_front();
                if (first < 0) first = c;
                chk($sformatf("feed_a_t%0d", e.t), {A3, A2, A1, A0}, e.a);
                chk($sformatf("feed_b_t%0d", e.t), {B3, B2, B1, B0}, e.b);
                if (use_tbl) begin
                    for (int k = 0; k < 3; k++) begin
                        if (tbl[k].t == e.t) begin
                            chk($sformatf("tbl_a_t%0d", e.t), {A3, A2, A1, A0}, tbl[k].a);
                            chk($sformatf("tbl_b_t%0d", e.t), {B3, B2, B1, B0}, tbl[k].b);
                        end
                    end
                end
                if (e.t == abort_t) begin
                    reset = 1'b1;
                    #1;
                    chk("rst_out_a", {A3, A2, A1, A0}, 32'd0);
                    chk("rst_out_b", {B3, B2, B1, B0}, 32'd0);
                    chk("rst_arr_rst", 32'(arr_rst), 32'd1);
                    step();
                    reset = 1'b0;
                    #1;
                    chk("post_rst_state", 32'(state_o), 32'd0);
                    chk("post_rst_ready", 32'(rx_ready), 32'd1);
                    chk("post_rst_busy", 32'(busy), 32'd0);
                    chk("post_rst_a", {A3, A2, A1, A0}, 32'd0);
                    sb.delete();
                    return;
                end
            end
        end
        chk("feed_latency", first, 32'd0);
        chk("feed_left", sb.size(), 32'd0);
        step();
        chk("drain_state", 32'(state_o), 32'd4);
        chk("drain_out", {A3, A2, A1, A0, B3, B2, B1, B0} == 64'd0, 32'd1);
        chk("drain_busy", 32'(busy), 32'd1);
    endtask

    task automatic finish_done();
        arr_done = 1'b1;
        step();
        arr_done = 1'b0;
        chk("done_state", 32'(state_o), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_ready", 32'(rx_ready), 32'd1);
    endtask

    initial begin
        int n;
        // Expected streams for A = identity, B = 1..16, packed {lane3..lane0}.
        tbl[0] = '{t: 0, a: {8'd0, 8'd0, 8'd0, 8'd1}, b: {8'd0, 8'd0, 8'd0, 8'd1}};
        tbl[1] = '{t: 3, a: {8'd0, 8'd0, 8'd0, 8'd0}, b: {8'd4, 8'd7, 8'd10, 8'd13}};
        tbl[2] = '{t: 6, a: {8'd1, 8'd0, 8'd0, 8'd0}, b: {8'd16, 8'd0, 8'd0, 8'd0}};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        start    = 1'b0;
        arr_done = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_ready", 32'(rx_ready), 32'd1);
        chk("rst_arr_rst", 32'(arr_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {A3, A2, A1, A0, B3, B2, B1, B0} == 64'd0, 32'd1);
        chk("rst_drop", 32'(drop_err), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_arr_rst", 32'(arr_rst), 32'd0);

        // Identity A, B = 1..16.
        for (int i = 0; i < 16; i++) begin
            frame[i]      = ((i / 4) == (i % 4)) ? 8'd1 : 8'd0;
            frame[16 + i] = 8'(i + 1);
        end
        send_range(0, 31);
        chk("load_ready_state", 32'(state_o), 32'd1);
        chk("load_rx_ready", 32'(rx_ready), 32'd0);
        arr_done = 1'b1;
        step();
        arr_done = 1'b0;
        chk("spurious_done", 32'(state_o), 32'd1);
        run_feed(-1, 1'b1);
        finish_done();

        // 33 bytes back-to-back: the extra one is dropped.
        random_frame();
        send_range(0, 30);
        chk("pre32_state", 32'(state_o), 32'd0);
        send_byte(frame[31]);
        chk("post32_state", 32'(state_o), 32'd1);
        chk("post32_drop", 32'(drop_err), 32'd0);
        send_byte(8'hEE);
        chk("drop_pulse", 32'(drop_err), 32'd1);
        chk("drop_state", 32'(state_o), 32'd1);
        step();
        chk("drop_clear", 32'(drop_err), 32'd0);
        run_feed(-1, 1'b0);

        // No arr_done: drain times out.
        n = 0;
        while (state_o == 3'd4 && n < 40) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, 32'd15);
        chk("timeout_state", 32'(state_o), 32'd0);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);

        random_frame();
        send_byte(frame[0]);
        chk("timeout_err_clr", 32'(timeout_err), 32'd0);
        send_range(1, 9);
        start = 1'b1;
        #1;
        chk("load_start_rst", 32'(arr_rst), 32'd0);
        step();
        start = 1'b0;
        chk("load_start_state", 32'(state_o), 32'd0);
        chk("load_start_rst2", 32'(arr_rst), 32'd0);
        send_range(10, 30);
        chk("cnt_cont_state", 32'(state_o), 32'd0);
        send_byte(frame[31]);
        chk("cnt_cont_ready", 32'(state_o), 32'd1);

        // Reset during FEED at t=4.
        run_feed(4, 1'b0);

        random_frame();
        send_range(0, 30);
        chk("after_rst_cnt", 32'(state_o), 32'd0);
        send_byte(frame[31]);
        chk("after_rst_ready", 32'(state_o), 32'd1);
        run_feed(-1, 1'b0);
        finish_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
